// File: rtl/spw_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spw_tx_scheduler                                                |
// | Purpose  : SpaceWire TX character scheduler. It picks TIME, FCT, N-char    |
// |            or NULL for the single TX encoder and keeps the TX credit and   |
// |            the RX outstanding-credit counters.                             |
// | Options  : SPW_TX_SCHED_TC_EN enables the time-code path.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spw_tx_scheduler #(
    parameter int CREDIT_MAX = 56,
    parameter int FIFO_AW    = 6
) (
    input  wire logic               pclk,
    input  wire logic               resetn,
    input  wire logic               enable_tx,
    input  wire logic               send_null_tx,
    input  wire logic               send_fct_tx,
    input  wire logic               link_run,
    input  wire logic               rx_got_fct,
    input  wire logic               rx_got_nchar,
    input  wire logic [FIFO_AW:0]   rx_fifo_free,
    input  wire logic               tc_req,
    input  wire logic [7:0]         tc_data,
    output logic                    tc_ack,
    input  wire logic               data_valid,
    input  wire logic [8:0]         data_in,
    output logic                    data_ready,
    output logic                    tx_char_valid,
    output logic [1:0]              tx_char_type,
    output logic [8:0]              tx_char_data,
    input  wire logic               tx_char_ready,
    output logic [5:0]              tx_credit,
    output logic [5:0]              rx_outstanding,
    output logic                    credit_error
);

    localparam int             c_CW        = 6;
    localparam int             c_EW        = 16;
    localparam logic [c_CW-1:0] c_CREDIT_HI = c_CW'(CREDIT_MAX - 8);
    localparam logic [1:0]     c_TYPE_NULL  = 2'd0;
    localparam logic [1:0]     c_TYPE_FCT   = 2'd1;
    localparam logic [1:0]     c_TYPE_NCHAR = 2'd2;
    localparam logic [1:0]     c_TYPE_TIME  = 2'd3;

    logic              r_slot_valid;
    logic [1:0]        r_slot_type;
    logic [8:0]        r_slot_data;
    logic [c_CW-1:0]   r_tx_credit;
    logic [c_CW-1:0]   r_rx_outstanding;
    logic              r_credit_error;

    logic              w_load;
    logic              w_time_elig;
    logic              w_fct_elig;
    logic              w_nchar_elig;
    logic              w_null_elig;
    logic              w_time_load;
    logic              w_fct_load;
    logic              w_nchar_load;
    logic [c_EW-1:0]   w_free_ext;
    logic [c_EW-1:0]   w_need_ext;
    logic              w_credit_ovf;
    logic              w_credit_add;
    logic              w_rxo_dec;
    logic [c_CW:0]     w_credit_nxt;
    logic [c_CW:0]     w_rxo_nxt;
    logic              w_slot_valid_nxt;
    logic [1:0]        w_slot_type_nxt;
    logic [8:0]        w_slot_data_nxt;

    // A new character may enter the slot when it is empty or being consumed.
    assign w_load = enable_tx && (!r_slot_valid || tx_char_ready);

`ifdef SPW_TX_SCHED_TC_EN
    assign w_time_elig = link_run && tc_req;
`else
    logic w_tc_unused;
    assign w_tc_unused = ^{tc_req, tc_data};
    assign w_time_elig = 1'b0;
`endif

    assign w_free_ext   = c_EW'(rx_fifo_free);
    assign w_need_ext   = c_EW'(r_rx_outstanding) + c_EW'(8);
    assign w_fct_elig   = send_fct_tx && (r_rx_outstanding <= c_CREDIT_HI)
                          && (w_free_ext >= w_need_ext);
    assign w_nchar_elig = link_run && data_valid && (r_tx_credit != '0);
    assign w_null_elig  = send_null_tx;

    assign w_time_load  = w_load && w_time_elig;
    assign w_fct_load   = w_load && !w_time_elig && w_fct_elig;
    assign w_nchar_load = w_load && !w_time_elig && !w_fct_elig && w_nchar_elig;

    assign tc_ack     = w_time_load;
    assign data_ready = w_nchar_load;

    // Credit above CREDIT_MAX-8 cannot absorb another FCT; drop the +8.
    assign w_credit_ovf = rx_got_fct && (r_tx_credit > c_CREDIT_HI);
    assign w_credit_add = rx_got_fct && !w_credit_ovf;
    assign w_credit_nxt = (c_CW+1)'(r_tx_credit)
                          + (w_credit_add ? (c_CW+1)'(8) : '0)
                          - (w_nchar_load ? (c_CW+1)'(1) : '0);

    assign w_rxo_dec = rx_got_nchar && ((r_rx_outstanding != '0) || w_fct_load);
    assign w_rxo_nxt = (c_CW+1)'(r_rx_outstanding)
                       + (w_fct_load ? (c_CW+1)'(8) : '0)
                       - (w_rxo_dec ? (c_CW+1)'(1) : '0);

    always_comb begin
        w_slot_valid_nxt = r_slot_valid;
        w_slot_type_nxt  = r_slot_type;
        w_slot_data_nxt  = r_slot_data;
        if (!enable_tx) begin
            w_slot_valid_nxt = 1'b0;
            w_slot_type_nxt  = c_TYPE_NULL;
            w_slot_data_nxt  = '0;
        end else if (w_load) begin
            w_slot_valid_nxt = 1'b1;
            w_slot_data_nxt  = '0;
            if (w_time_elig) begin
                w_slot_type_nxt = c_TYPE_TIME;
                w_slot_data_nxt = {1'b0, tc_data};
            end else if (w_fct_elig) begin
                w_slot_type_nxt = c_TYPE_FCT;
            end else if (w_nchar_elig) begin
                w_slot_type_nxt = c_TYPE_NCHAR;
                w_slot_data_nxt = data_in;
            end else if (w_null_elig) begin
                w_slot_type_nxt = c_TYPE_NULL;
            end else begin
                w_slot_valid_nxt = 1'b0;
                w_slot_type_nxt  = c_TYPE_NULL;
            end
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            r_slot_valid     <= 1'b0;
            r_slot_type      <= c_TYPE_NULL;
            r_slot_data      <= '0;
            r_tx_credit      <= '0;
            r_rx_outstanding <= '0;
            r_credit_error   <= 1'b0;
        end else begin
            r_slot_valid <= w_slot_valid_nxt;
            r_slot_type  <= w_slot_type_nxt;
            r_slot_data  <= w_slot_data_nxt;
            if (!enable_tx) begin
                r_tx_credit      <= '0;
                r_rx_outstanding <= '0;
                r_credit_error   <= 1'b0;
            end else begin
                r_tx_credit      <= w_credit_nxt[c_CW-1:0];
                r_rx_outstanding <= w_rxo_nxt[c_CW-1:0];
                r_credit_error   <= w_credit_ovf;
            end
        end
    end

    assign tx_char_valid  = r_slot_valid;
    assign tx_char_type   = r_slot_type;
    assign tx_char_data   = r_slot_data;
    assign tx_credit      = r_tx_credit;
    assign rx_outstanding = r_rx_outstanding;
    assign credit_error   = r_credit_error;

endmodule
`default_nettype wire

// File: doc/spw_tx_scheduler.md
# spw_tx_scheduler

SpaceWire transmit character scheduler. Sits between the link FSM, the RX FIFO and the TX encoder, and decides which character the single TX encoder sends next: time-code, FCT, N-char or NULL. It keeps the TX credit counter and the RX outstanding-FCT counter required by ECSS-E-ST-50-12C flow control.

## Interface
- CREDIT_MAX, 56: max TX credit and max RX outstanding (7 FCTs × 8)
- FIFO_AW, 6: RX FIFO free-count width minus 1

- pclk  in  1  clock
- resetn  in  1  async active-low reset
- enable_tx, send_null_tx, send_fct_tx  in  1  from link FSM
- link_run  in  1  FSM in Run state
- rx_got_fct  in  1  pulse, FCT received
- rx_got_nchar  in  1  pulse, N-char written to RX FIFO
- rx_fifo_free  in  FIFO_AW+1  free RX FIFO entries
- tc_req  in  1  time-code request (level)
- tc_data  in  8  time-code value
- tc_ack  out  1  pulse, time-code loaded
- data_valid  in  1  N-char source valid
- data_in  in  9  bit8=control (EOP/EEP), bits7:0 data
- data_ready  out  1  N-char taken this cycle
- tx_char_valid  out  1  output character valid
- tx_char_type  out  2  0=NULL 1=FCT 2=NCHAR 3=TIME
- tx_char_data  out  9  payload (N-char or {1'b0,tc_data}), 0 for NULL/FCT
- tx_char_ready  in  1  encoder accepts character
- tx_credit  out  6  current TX credit
- rx_outstanding  out  6  credit granted to far end
- credit_error  out  1  pulse, credit overflow

## Operation
- Output slot: one register {valid,type,data}. "Load" happens when slot empty or tx_char_ready=1. At load, the winning character is selected by fixed priority: TIME > FCT > NCHAR > NULL.
- TIME eligible: link_run & tc_req. On load, tc_ack=1 for that cycle.
- FCT eligible: send_fct_tx & rx_outstanding ≤ CREDIT_MAX−8 & rx_fifo_free ≥ rx_outstanding+8.
- NCHAR eligible: link_run & data_valid & tx_credit>0. data_ready=1 combinationally in the load cycle.
- NULL eligible: send_null_tx. If nothing is eligible, the slot empties (tx_char_valid=0). With enable_tx=1 and send_null_tx=0 (Ready), nothing is sent.
- Counters commit at load, not at encoder acceptance.
- tx_credit: +8 on rx_got_fct, −1 on NCHAR load; both can occur in the same cycle (net +7).
  - If rx_got_fct while tx_credit > CREDIT_MAX−8: credit_error pulses 1 cycle and the +8 is discarded. A same-cycle −1 still applies.
- rx_outstanding: +8 on FCT load, −1 on rx_got_nchar; same-cycle net +7. Saturates at 0 on decrement.
- enable_tx=0: next cycle slot cleared, tx_credit=0, rx_outstanding=0, no ack/ready issued. A pending tc_req is not acked.

## Timing
- Reset values: all outputs 0, both counters 0, slot empty.
- Latency: eligible request at cycle N → tx_char_valid at N+1 (registered). Back-to-back throughput is 1 char/cycle when tx_char_ready is held 1.
- Handshake: while tx_char_valid=1 and tx_char_ready=0, type and data are held stable.
- Counter outputs are registered and reflect loads/pulses of the previous cycle.
- Wrap-around is impossible: counters are bounded to 0..CREDIT_MAX by the rules above.
- Async reset mid-character: slot dropped immediately, no ack.

## Configuration
- SPW_TX_SCHED_TC_EN
  - Defined: time-code path active as above.
  - Undefined: TIME never eligible, tc_ack tied 0, type 3 never emitted. Ports are retained and tc_req/tc_data are ignored.

## Test plan
- Reset, enable_tx=1, send_null_tx=1, tx_char_ready=1 → continuous type 0, counters 0.
- send_fct_tx=1, rx_fifo_free=63 → exactly 7 FCTs loaded, then NULLs; rx_outstanding=56. 8 rx_got_nchar pulses → rx_outstanding=48, one more FCT.
- link_run=1, three rx_got_fct → tx_credit=24. 30 N-chars offered → 24 sent, then NULLs; data_ready stays 0 with tx_credit=0.
- tx_credit=56, rx_got_fct → credit_error pulse, tx_credit stays 56. Same with a concurrent NCHAR load → tx_credit=55, credit_error=1.
- tc_req=1 together with data_valid and an FCT eligible → type 3 first with tc_ack pulse, then FCT, then NCHAR. Repeat with macro undefined → no type 3, tc_ack=0.
- tx_char_ready=0 for 5 cycles with NCHAR 0x1A5 loaded → output held stable. Drop enable_tx → valid=0 and counters 0 next cycle.
